// File: rtl/matled_pkg.sv
// Shared types and encodings for the 2x4 LED matrix scan controller.
// State enum, column/row drive constants and a column row-slice helper.
package matled_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam logic [1:0] COL_NONE = 2'b00;
  localparam logic [1:0] COL0_SEL = 2'b01;
  localparam logic [1:0] COL1_SEL = 2'b10;
  localparam logic [3:0] ROWS_OFF = 4'b1111;

  // Row bits of one column: bit 2i+col of the pattern is row i.
  function automatic logic [3:0] col_rows(
    input logic [7:0] pat,
    input logic       col
  );
    logic [3:0] r;
    if (col) r = {pat[7], pat[5], pat[3], pat[1]};
    else     r = {pat[6], pat[4], pat[2], pat[0]};
    return r;
  endfunction

endpackage

// File: rtl/matled_scan_timer.sv
// Loadable down-counter timing the BLANK and DRIVE periods of a slot.
// Ports: clock, reset_n (sync, active-low), clear, load/load_val, en, tc.
module matled_scan_timer #(
  parameter int W = 19
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  // A period of N cycles is loaded as N-1; tc marks its last cycle.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = en && (cnt == '0);

endmodule

// File: rtl/matled_scan_ctrl.sv
// Column scan controller for a 2x4 LED matrix with a double-buffered
// frame pattern swapped in only at frame boundaries.
// Ports: clock, reset_n (sync, active-low), enable_i, pattern_i[7:0],
//   pattern_valid_i, pattern_ready_o, l[3:0] (rows, active-low),
//   c[1:0] (columns, one-hot), frame_o (boundary pulse).
// Build option: MATLED_BLANK_EN adds a BLANK_CYCLES gap before each
//   column; without it columns switch directly and BLANK_CYCLES is unused.
module matled_scan_ctrl
  import matled_pkg::*;
#(
  parameter int DWELL_CYCLES = 524288,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable_i,
  input  logic [7:0] pattern_i,
  input  logic       pattern_valid_i,
  output logic       pattern_ready_o,
  output logic [3:0] l,
  output logic [1:0] c,
  output logic       frame_o
);

  localparam int W = $clog2(DWELL_CYCLES);

`ifdef MATLED_BLANK_EN
  localparam logic [W-1:0] BLANK_LEN = W'(BLANK_CYCLES - 1);
  localparam logic [W-1:0] DRIVE_LEN =
    W'(DWELL_CYCLES - BLANK_CYCLES - 1);
`else
  localparam logic [W-1:0] DRIVE_LEN = W'(DWELL_CYCLES - 1);
`endif

  if (!(DWELL_CYCLES > BLANK_CYCLES && BLANK_CYCLES >= 1))
  begin : g_param_chk
    $error("matled_scan_ctrl: need DWELL > BLANK >= 1");
  end

  state_t       state;
  state_t       state_nx;
  logic         col;
  logic         col_nx;
  logic [7:0]   display;
  logic [7:0]   pending;
  logic [7:0]   display_nx;
  logic         pend_full;
  logic         xfer;
  logic         boundary;
  logic         t_clear;
  logic         t_load;
  logic [W-1:0] t_val;
  logic         tc;
  logic [1:0]   c_nx;
  logic [3:0]   l_nx;

  matled_scan_timer #(
    .W (W)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (t_clear),
    .load     (t_load),
    .load_val (t_val),
    .en       (state != IDLE),
    .tc       (tc)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      col   <= 1'b0;
    end else begin
      state <= state_nx;
      col   <= col_nx;
    end
  end

  always_comb begin
    state_nx = state;
    col_nx   = col;
    t_clear  = 1'b0;
    t_load   = 1'b0;
    t_val    = '0;
    boundary = 1'b0;
    if (!enable_i) begin
      state_nx = IDLE;
      col_nx   = 1'b0;
      t_clear  = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          col_nx = 1'b0;
          t_load = 1'b1;
`ifdef MATLED_BLANK_EN
          state_nx = BLANK;
          t_val    = BLANK_LEN;
`else
          state_nx = DRIVE;
          t_val    = DRIVE_LEN;
`endif
        end
`ifdef MATLED_BLANK_EN
        BLANK: begin
          if (tc) begin
            state_nx = DRIVE;
            t_load   = 1'b1;
            t_val    = DRIVE_LEN;
          end
        end
`endif
        DRIVE: begin
          if (tc) begin
            col_nx   = ~col;
            boundary = col;
            t_load   = 1'b1;
`ifdef MATLED_BLANK_EN
            state_nx = BLANK;
            t_val    = BLANK_LEN;
`else
            state_nx = DRIVE;
            t_val    = DRIVE_LEN;
`endif
          end
        end
        default: begin
          state_nx = IDLE;
          col_nx   = 1'b0;
        end
      endcase
    end
  end

  // Outputs are decoded from next-state values and registered, so the
  // pins change on the same edge as the state they reflect.
  always_comb begin
    c_nx = COL_NONE;
    l_nx = ROWS_OFF;
    if (state_nx == DRIVE) begin
      c_nx = col_nx ? COL1_SEL : COL0_SEL;
      l_nx = ~col_rows(display_nx, col_nx);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      c       <= COL_NONE;
      l       <= ROWS_OFF;
      frame_o <= 1'b0;
    end else begin
      c       <= c_nx;
      l       <= l_nx;
      frame_o <= boundary;
    end
  end

  assign xfer       = pattern_valid_i && !pend_full;
  assign display_nx = (boundary && pend_full) ? pending : display;

  // A transfer landing on a boundary goes to pending only; it is
  // shown at the following boundary.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      display   <= 8'h00;
      pending   <= 8'h00;
      pend_full <= 1'b0;
    end else begin
      display <= display_nx;
      if (boundary && pend_full) begin
        pend_full <= 1'b0;
      end
      if (xfer) begin
        pending   <= pattern_i;
        pend_full <= 1'b1;
      end
    end
  end

  assign pattern_ready_o = ~pend_full;

endmodule

// File: tb/tb_matled_scan_ctrl.sv
// Self-checking bench for matled_scan_ctrl with DWELL=8, BLANK=2.
// Outputs are compared every cycle against a slot-arithmetic model.
module tb_matled_scan_ctrl;

  localparam int D = 8;
  localparam int B = 2;
`ifdef MATLED_BLANK_EN
  localparam int BLK = B;
`else
  localparam int BLK = 0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable_i = 1'b0;
  logic [7:0] pattern_i = 8'h00;
  logic       pattern_valid_i = 1'b0;
  logic       pattern_ready_o;
  logic [3:0] l;
  logic [1:0] c;
  logic       frame_o;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: t counts cycles since scan start within a frame.
  bit         run = 0;
  bit         fp = 0;
  bit         full = 0;
  int         t = 0;
  logic [7:0] disp = 8'h00;
  logic [7:0] pend = 8'h00;
  logic [7:0] got;

  always #5 clock = ~clock;

  matled_scan_ctrl #(
    .DWELL_CYCLES (D),
    .BLANK_CYCLES (B)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable_i        (enable_i),
    .pattern_i       (pattern_i),
    .pattern_valid_i (pattern_valid_i),
    .pattern_ready_o (pattern_ready_o),
    .l               (l),
    .c               (c),
    .frame_o         (frame_o)
  );

  // Expected {c, l, frame_o, pattern_ready_o}.
  function automatic logic [7:0] exp_out();
    logic [1:0] ec;
    logic [3:0] el;
    int col;
    ec = 2'b00;
    el = 4'hF;
    if (run && (t % D) >= BLK) begin
      col = (t / D) % 2;
      ec  = (col == 1) ? 2'b10 : 2'b01;
      for (int i = 0; i < 4; i++) el[i] = ~disp[2*i+col];
    end
    return {ec, el, fp, ~full};
  endfunction

  // One clock edge; model consumes the inputs the DUT sampled.
  task automatic cycle();
    bit         en = enable_i;
    bit         v = pattern_valid_i;
    bit         r = reset_n;
    logic [7:0] p = pattern_i;
    bit         x;
    @(posedge clock);
    #1;
    if (!r) begin
      run = 0; t = 0; disp = 8'h00; full = 0; fp = 0;
    end else begin
      x  = v && !full;
      fp = 0;
      if (!en) begin
        run = 0; t = 0;
      end else if (!run) begin
        run = 1; t = 0;
      end else begin
        t++;
        if (t == 2*D) begin
          t  = 0;
          fp = 1;
          if (full) begin
            disp = pend;
            full = 0;
          end
        end
      end
      if (x) begin
        pend = p;
        full = 1;
      end
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    enable_i = 1'b1;
    repeat (2) begin
      cycle();
      got = {c, l, frame_o, pattern_ready_o};
      n_chk++;
      if (got !== 8'b00_1111_0_1) begin
        n_fail++;
        $display("FAIL reset got=%b exp=%b", got, 8'b00_1111_0_1);
      end
    end
    reset_n  = 1'b1;
    enable_i = 1'b0;
    cycle();
  endtask

  task automatic test_scan_pattern();
    pattern_valid_i = 1'b1;
    pattern_i       = 8'hA5;
    cycle();
    pattern_valid_i = 1'b0;
    pattern_i       = 8'h00;
    cycle();
    n_chk++;
    if (pattern_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready got=%b exp=0", pattern_ready_o);
    end
    enable_i = 1'b1;
    repeat (3*2*D) begin
      cycle();
      got = {c, l, frame_o, pattern_ready_o};
      n_chk++;
      if (got !== exp_out()) begin
        n_fail++;
        $display("FAIL scan t=%0d got=%b exp=%b", t, got, exp_out());
      end
    end
  endtask

  task automatic test_mid_transfer();
    bit hit = 0;
    for (int k = 0; k < 4*D && !hit; k++) begin
      cycle();
      hit = run && t == BLK + 1;
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL mid_wait got=timeout exp=col0");
    end
    pattern_valid_i = 1'b1;
    pattern_i       = 8'h0F;
    cycle();
    pattern_valid_i = 1'b0;
    repeat (2*2*D) begin
      got = {c, l, frame_o, pattern_ready_o};
      n_chk++;
      if (got !== exp_out()) begin
        n_fail++;
        $display("FAIL mid_xfer t=%0d got=%b exp=%b", t, got, exp_out());
      end
      cycle();
    end
  endtask

  task automatic test_hold_valid();
    pattern_valid_i = 1'b1;
    pattern_i       = 8'h33;
    repeat (5) begin
      cycle();
      got = {c, l, frame_o, pattern_ready_o};
      n_chk++;
      if (got !== exp_out()) begin
        n_fail++;
        $display("FAIL hold33 t=%0d got=%b exp=%b", t, got, exp_out());
      end
    end
    pattern_i = 8'hCC;
    repeat (3*2*D) begin
      cycle();
      got = {c, l, frame_o, pattern_ready_o};
      n_chk++;
      if (got !== exp_out()) begin
        n_fail++;
        $display("FAIL holdCC t=%0d got=%b exp=%b", t, got, exp_out());
      end
    end
    pattern_valid_i = 1'b0;
  endtask

  task automatic test_boundary_xfer();
    bit hit = 0;
    for (int k = 0; k < 4*2*D && !hit; k++) begin
      cycle();
      hit = run && !full && t == 2*D - 1;
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL bnd_wait got=timeout exp=boundary");
    end
    pattern_valid_i = 1'b1;
    pattern_i       = 8'h5A;
    cycle();
    pattern_valid_i = 1'b0;
    repeat (2*2*D + 2) begin
      got = {c, l, frame_o, pattern_ready_o};
      n_chk++;
      if (got !== exp_out()) begin
        n_fail++;
        $display("FAIL bnd_xfer t=%0d got=%b exp=%b", t, got, exp_out());
      end
      cycle();
    end
  endtask

  task automatic test_enable_drop();
    bit hit = 0;
    for (int k = 0; k < 4*D && !hit; k++) begin
      cycle();
      hit = run && (t % D) >= BLK && (t % D) < D - 1;
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL en_wait got=timeout exp=drive");
    end
    enable_i = 1'b0;
    repeat (3) begin
      cycle();
      got = {c, l, frame_o, pattern_ready_o};
      n_chk++;
      if (got[7:2] !== 6'b00_1111 || got !== exp_out()) begin
        n_fail++;
        $display("FAIL en_drop got=%b exp=%b", got, exp_out());
      end
    end
    enable_i = 1'b1;
    repeat (2*D + BLK + 1) begin
      cycle();
      got = {c, l, frame_o, pattern_ready_o};
      n_chk++;
      if (got !== exp_out()) begin
        n_fail++;
        $display("FAIL re_en t=%0d got=%b exp=%b", t, got, exp_out());
      end
    end
  endtask

  task automatic test_reset_mid();
    pattern_valid_i = 1'b1;
    pattern_i       = 8'h77;
    cycle();
    pattern_valid_i = 1'b0;
    repeat (3) cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    got = {c, l, frame_o, pattern_ready_o};
    n_chk++;
    if (got !== 8'b00_1111_0_1) begin
      n_fail++;
      $display("FAIL rst_mid got=%b exp=%b", got, 8'b00_1111_0_1);
    end
    repeat (3*2*D) begin
      cycle();
      got = {c, l, frame_o, pattern_ready_o};
      n_chk++;
      if (got !== exp_out()) begin
        n_fail++;
        $display("FAIL post_rst t=%0d got=%b exp=%b", t, got, exp_out());
      end
    end
  endtask

  task automatic test_random();
    repeat (800) begin
      enable_i        = ($urandom_range(0, 39) != 0);
      pattern_valid_i = ($urandom_range(0, 3) == 0);
      pattern_i       = 8'($urandom);
      cycle();
      got = {c, l, frame_o, pattern_ready_o};
      n_chk++;
      if (got !== exp_out()) begin
        n_fail++;
        $display("FAIL random t=%0d got=%b exp=%b", t, got, exp_out());
      end
    end
    pattern_valid_i = 1'b0;
    enable_i        = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan_pattern();
    test_mid_transfer();
    test_hold_valid();
    test_boundary_xfer();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
